seq_detect_mealy_param: RTL

//  Parametrised Mealy serial-pattern detector: next generation of the fixed 10110 detector.

---
 rtl/seq_detect_mealy_param.sv | 107 ++++++++++
 1 files changed

// File: rtl/seq_detect_mealy_param.sv
`default_nettype none
// ============================================================================
// Module      : seq_detect_mealy_param
// Description : Parametrised Mealy serial-pattern detector. Matches the last
//               N accepted bits (MSB = oldest) against a runtime-loadable
//               pattern, in overlapping or non-overlapping mode, and keeps a
//               saturating match counter with a sticky saturation flag.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_mealy_param #(
    parameter int             N         = 5,
    parameter logic [N-1:0]   RESET_PAT = 5'b10110,
    parameter int             CW        = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          din,
    input  logic          pat_load,
    input  logic [N-1:0]  pat_in,
    input  logic          overlap,
    input  logic          cnt_clr,
    output logic          match,
    output logic          match_q,
    output logic [CW-1:0] match_cnt,
    output logic          cnt_sat
);

    // Fill counter must hold 0..N-1.
    localparam int            FW          = (N > 2) ? $clog2(N) : 1;
    localparam logic [FW-1:0] c_FILL_FULL = FW'(N - 1);
    localparam logic [CW-1:0] c_CNT_MAX   = {CW{1'b1}};
    localparam logic [CW-1:0] c_CNT_ONE   = CW'(1);

    logic [N-1:0]  r_pat;
    logic [N-2:0]  r_hist;      // last N-1 accepted bits, [0] newest
    logic [FW-1:0] r_fill;      // number of valid bits in r_hist
    logic          r_match_q;
    logic [CW-1:0] r_cnt;
    logic          r_sat;

    logic [N-1:0]  w_window;
    logic          w_accept;
    logic          w_match;
    logic [CW-1:0] w_cnt_next;
    logic          w_sat_next;

    // Candidate window: stored history plus the bit being presented now.
    assign w_window = {r_hist, din};
    assign w_accept = en & ~pat_load;
    assign w_match  = w_accept & ~rst & (r_fill == c_FILL_FULL) & (w_window == r_pat);

    assign match     = w_match;
    assign match_q   = r_match_q;
    assign match_cnt = r_cnt;
    assign cnt_sat   = r_sat;

    // Pattern register, bit history and fill level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat  <= RESET_PAT;
            r_hist <= '0;
            r_fill <= '0;
        end else if (pat_load) begin
            // A new pattern invalidates any partial progress.
            r_pat  <= pat_in;
            r_hist <= '0;
            r_fill <= '0;
        end else if (en) begin
            r_hist <= w_window[N-2:0];
            if (w_match) begin
                // Non-overlapping mode needs N fresh bits before the next hit.
                r_fill <= overlap ? c_FILL_FULL : '0;
            end else if (r_fill != c_FILL_FULL) begin
                r_fill <= r_fill + FW'(1);
            end
        end
    end

    // Next value of the saturating counter and its sticky flag.
    always_comb begin
        w_cnt_next = r_cnt;
        w_sat_next = r_sat;
        if (cnt_clr) begin
            w_cnt_next = w_match ? c_CNT_ONE : '0;
            w_sat_next = w_match & (c_CNT_ONE == c_CNT_MAX);
        end else if (w_match && (r_cnt != c_CNT_MAX)) begin
            w_cnt_next = r_cnt + c_CNT_ONE;
            w_sat_next = r_sat | ((r_cnt + c_CNT_ONE) == c_CNT_MAX);
        end
    end

    // Registered match copy, counter and saturation flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_match_q <= 1'b0;
            r_cnt     <= '0;
            r_sat     <= 1'b0;
        end else begin
            r_match_q <= w_match;
            r_cnt     <= w_cnt_next;
            r_sat     <= w_sat_next;
        end
    end

endmodule
`default_nettype wire
